// File: rtl/sticky_shift_round_pipe.sv
// Right shift with round-to-nearest-even (guard/sticky), two-stage valid/ready pipeline,
// plus a saturating counter of delivered inexact results.
`timescale 1ns/1ps
module sticky_shift_round_pipe #(
  parameter int WIDTH   = 8,
  parameter int N_WIDTH = $clog2(WIDTH) + 1,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [N_WIDTH-1:0] in_n,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_inexact,
  output logic               out_round_up,
  input  logic               clear_count,
  output logic [CNT_W-1:0]   inexact_count
);

  localparam logic [N_WIDTH-1:0] N_FULL = N_WIDTH'(WIDTH);

  // Per-shift-amount taps: entry k is the guard / sticky for a shift of k.
  logic [WIDTH:0] guard_sel;
  logic [WIDTH:0] sticky_sel;

  assign guard_sel[0]  = 1'b0;
  assign sticky_sel[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi <= WIDTH; gi++) begin : g_taps
      localparam logic [WIDTH-1:0] LOW_MASK = {WIDTH{1'b1}} >> (WIDTH - gi + 1);
      assign guard_sel[gi]  = in_data[gi-1];
      assign sticky_sel[gi] = |(in_data & LOW_MASK);
    end
  endgenerate

  // Stage 1 next values
  logic [WIDTH-1:0] s1_q_next;
  logic             s1_g_next;
  logic             s1_s_next;
  logic             s1_l_next;

  always_comb begin
    s1_q_next = in_data >> in_n;
    s1_g_next = 1'b0;
    s1_s_next = 1'b0;
    if (in_n > N_FULL) begin
      s1_s_next = |in_data;
    end else begin
      s1_g_next = guard_sel[in_n];
      s1_s_next = sticky_sel[in_n];
    end
    s1_l_next = s1_q_next[0];
  end

  // Stage 1 registers
  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_q_reg;
  logic             s1_g_reg;
  logic             s1_s_reg;
  logic             s1_l_reg;

  // Stage 2 (output) registers
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             out_inexact_reg;
  logic             out_round_up_reg;
  logic [CNT_W-1:0] count_reg;

  logic s1_advance;

  assign s1_advance = !out_valid_reg || out_ready;
  assign in_ready   = !s1_valid_reg || s1_advance;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_q_reg     <= '0;
      s1_g_reg     <= 1'b0;
      s1_s_reg     <= 1'b0;
      s1_l_reg     <= 1'b0;
    end else if (in_ready) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_q_reg <= s1_q_next;
        s1_g_reg <= s1_g_next;
        s1_s_reg <= s1_s_next;
        s1_l_reg <= s1_l_next;
      end
    end
  end

  // Stage 2: round-half-to-even increment; q < 2^(WIDTH-1) whenever g can be set, so no carry-out.
  logic             round_up_next;
  logic             inexact_next;
  logic [WIDTH-1:0] data_next;

  always_comb begin
    round_up_next = s1_g_reg && (s1_s_reg || s1_l_reg);
    inexact_next  = s1_g_reg || s1_s_reg;
    data_next     = s1_q_reg + WIDTH'(round_up_next);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_reg    <= 1'b0;
      out_data_reg     <= '0;
      out_inexact_reg  <= 1'b0;
      out_round_up_reg <= 1'b0;
    end else if (s1_advance) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_data_reg     <= data_next;
        out_inexact_reg  <= inexact_next;
        out_round_up_reg <= round_up_next;
      end
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear_count) begin
      count_reg <= '0;
    end else if (out_valid_reg && out_ready && out_inexact_reg && !(&count_reg)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign out_valid     = out_valid_reg;
  assign out_data      = out_data_reg;
  assign out_inexact   = out_inexact_reg;
  assign out_round_up  = out_round_up_reg;
  assign inexact_count = count_reg;

endmodule

// File: tb/tb_sticky_shift_round_pipe.sv
// Scoreboard bench for sticky_shift_round_pipe: directed spec vectors, backpressure,
// counter, mid-stream reset and randomized traffic against an exact-division reference.
`timescale 1ns/1ps
module tb_sticky_shift_round_pipe;

  typedef struct packed {
    logic [7:0] data;
    logic       inexact;
    logic       round_up;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [3:0] in_n = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_inexact;
  logic       out_round_up;
  logic       clear_count = 1'b0;
  logic [15:0] inexact_count;

  logic       sat_in_ready;
  logic       sat_out_valid;
  logic [7:0] sat_out_data;
  logic       sat_out_inexact;
  logic       sat_out_round_up;
  logic [1:0] sat_count;

  int n_vec = 0;
  int n_bad = 0;
  exp_t sb[$];

  sticky_shift_round_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_n(in_n),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_inexact(out_inexact), .out_round_up(out_round_up),
    .clear_count(clear_count), .inexact_count(inexact_count)
  );

  sticky_shift_round_pipe #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(in_data), .in_n(in_n),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data),
    .out_inexact(sat_out_inexact), .out_round_up(sat_out_round_up),
    .clear_count(clear_count), .inexact_count(sat_count)
  );

  always #5 clock = ~clock;

  // Exact quotient d / 2^n rounded half-to-even.
  function automatic exp_t ref_model(input int d, input int n);
    exp_t r;
    int scale;
    int q;
    int rem;
    bit up;
    scale = 1 << n;
    q     = d / scale;
    rem   = d - q * scale;
    up    = (2 * rem > scale) || ((2 * rem == scale) && (q % 2 == 1));
    r.data     = 8'(q + int'(up));
    r.inexact  = (rem != 0);
    r.round_up = up;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic [3:0] n,
                     input logic ordy, input logic clr, input bit use_exp,
                     input exp_t e, output bit acc);
    @(posedge clock);
    #1;
    in_valid    = v;
    in_data     = d;
    in_n        = n;
    out_ready   = ordy;
    clear_count = clr;
    @(negedge clock);
    acc = v && in_ready && !reset;
    if (acc) begin
      sb.push_back(use_exp ? e : ref_model(int'(d), int'(n)));
      $display("in  data=%02h n=%0d", d, n);
    end
  endtask

  task automatic idle(input logic ordy, input int cycles);
    bit acc;
    for (int i = 0; i < cycles; i++) cyc(1'b0, 8'h00, 4'd0, ordy, 1'b0, 1'b0, '0, acc);
  endtask

  task automatic dir(input logic [7:0] d, input logic [3:0] n, input exp_t e);
    bit acc;
    cyc(1'b1, d, n, 1'b1, 1'b0, 1'b1, e, acc);
    chk("dir_accept", int'(acc), 1);
  endtask

  // Beat into an empty pipeline with out_ready high must show out_valid exactly 2 cycles later.
  task automatic lat_check(input logic [7:0] d, input logic [3:0] n, input bit use_exp, input exp_t e);
    bit acc;
    cyc(1'b1, d, n, 1'b1, 1'b0, use_exp, e, acc);
    chk("lat_accept", int'(acc), 1);
    idle(1'b1, 1);
    chk("lat_not_early", int'(out_valid), 0);
    idle(1'b1, 1);
    chk("lat_valid_at_2", int'(out_valid), 1);
  endtask

  task automatic do_reset_pulse();
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_inexact", int'(out_inexact), 0);
    chk("rst_out_round_up", int'(out_round_up), 0);
    chk("rst_count", int'(inexact_count), 0);
    chk("rst_count_sat", int'(sat_count), 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    clear_count = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #3;
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_in_ready", int'(in_ready), 1);
  endtask

  // Monitor: compares each output transfer to the scoreboard and tracks both counters.
  initial begin : monitor
    int   cnt_m;
    int   cnt_s_m;
    bit   hold;
    exp_t held;
    exp_t e;
    bit   inc;
    cnt_m = 0;
    cnt_s_m = 0;
    hold = 0;
    held = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        sb.delete();
        cnt_m = 0;
        cnt_s_m = 0;
        hold = 0;
      end else begin
        chk("count", int'(inexact_count), cnt_m);
        chk("count_sat", int'(sat_count), cnt_s_m);
        if (hold) chk("stall_stable", int'({out_valid, out_data, out_inexact, out_round_up}),
                      int'({1'b1, held}));
        inc = 0;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", int'({out_data, out_inexact, out_round_up}), -1);
          end else begin
            e = sb.pop_front();
            $display("out data=%02h inexact=%0d round_up=%0d (want %02h %0d %0d)",
                     out_data, out_inexact, out_round_up, e.data, e.inexact, e.round_up);
            chk("result", int'({out_data, out_inexact, out_round_up}), int'(e));
            inc = e.inexact;
          end
        end
        hold = out_valid && !out_ready;
        held = {out_data, out_inexact, out_round_up};
        if (clear_count) begin
          cnt_m = 0;
          cnt_s_m = 0;
        end else if (inc) begin
          if (cnt_m < 65535) cnt_m++;
          if (cnt_s_m < 3) cnt_s_m++;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bit acc;
    int idx;
    logic [7:0] bd[6];
    logic [3:0] bn[6];

    #1 reset = 1'b1;
    #1;
    chk("init_out_valid", int'(out_valid), 0);
    chk("init_out_data", int'(out_data), 0);
    chk("init_count", int'(inexact_count), 0);
    @(posedge clock);
    @(posedge clock);
    #3 reset = 1'b0;
    @(negedge clock);
    chk("init_in_ready", int'(in_ready), 1);

    // Directed vectors with hand-derived expectations
    lat_check(8'hB6, 4'd3, 1'b1, '{data: 8'h17, inexact: 1'b1, round_up: 1'b1});
    dir(8'h0C, 4'd3, '{data: 8'h02, inexact: 1'b1, round_up: 1'b1});
    dir(8'h14, 4'd3, '{data: 8'h02, inexact: 1'b1, round_up: 1'b0});
    dir(8'hFF, 4'd0, '{data: 8'hFF, inexact: 1'b0, round_up: 1'b0});
    dir(8'hC0, 4'd8, '{data: 8'h01, inexact: 1'b1, round_up: 1'b1});
    dir(8'h01, 4'd9, '{data: 8'h00, inexact: 1'b1, round_up: 1'b0});
    idle(1'b1, 3);
    chk("count_five", int'(inexact_count), 5);
    chk("count_saturated", int'(sat_count), 3);

    // Clear coinciding with an inexact output transfer
    cyc(1'b1, 8'h14, 4'd3, 1'b1, 1'b0, 1'b0, '0, acc);
    idle(1'b1, 1);
    chk("clr_out_valid", int'(out_valid), 0);
    cyc(1'b0, 8'h00, 4'd0, 1'b1, 1'b1, 1'b0, '0, acc);
    chk("clr_transfer_now", int'(out_valid && out_inexact), 1);
    idle(1'b1, 1);
    chk("clr_count_zero", int'(inexact_count), 0);

    // Backpressure: 6 beats, out_ready low for the first 4 cycles
    idle(1'b1, 3);
    for (int i = 0; i < 6; i++) begin
      bd[i] = 8'($urandom);
      bn[i] = 4'($urandom_range(0, 9));
    end
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      cyc(1'b1, bd[idx], bn[idx], 1'b0, 1'b0, 1'b0, '0, acc);
      if (acc) idx++;
    end
    chk("bp_buffered", idx, 2);
    chk("bp_in_ready_low", int'(in_ready), 0);
    for (int c = 0; c < 20 && idx < 6; c++) begin
      cyc(1'b1, bd[idx], bn[idx], 1'b1, 1'b0, 1'b0, '0, acc);
      if (acc) idx++;
    end
    chk("bp_all_accepted", idx, 6);
    idle(1'b1, 4);
    chk("bp_drained", sb.size(), 0);

    // Reset with two beats in flight
    cyc(1'b1, 8'hB6, 4'd3, 1'b0, 1'b0, 1'b0, '0, acc);
    cyc(1'b1, 8'h0C, 4'd3, 1'b0, 1'b0, 1'b0, '0, acc);
    idle(1'b0, 1);
    chk("pre_rst_out_valid", int'(out_valid), 1);
    do_reset_pulse();
    lat_check(8'($urandom), 4'($urandom_range(0, 15)), 1'b0, '0);
    idle(1'b1, 3);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      cyc(($urandom % 10) < 7, 8'($urandom), 4'($urandom_range(0, 15)),
          ($urandom % 10) < 7, ($urandom % 64) == 0, 1'b0, '0, acc);
    end
    idle(1'b1, 6);
    chk("final_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
